ro_puf_controller: RTL and testbench
====================================

Name: ro_puf_controller

Overview:
- Parametrised measurement sequencer for the ring-oscillator PUF chain. It generalises the fixed 2-bit mux select and single enable to NUM_RO oscillators.
- For each challenge (pair of oscillator indices) it performs these steps per oscillator:
  - clear the shared edge counter;
  - enable the selected oscillator for a fixed gate window;
  - wait for the counter to settle;
  - capture the count.
- It then compares the two counts and returns a response bit, a tie flag and both raw counts.
- Sits between the host/AXI register block and the existing mux/oscillator/counter chain. It drives that chain's select, enable and counter-reset inputs and samples its count output.

Parameters:
- NUM_RO, 4, number of ring oscillators behind the mux (>= 2).
- SEL_W, $clog2(NUM_RO), width of oscillator select.
- CNT_W, 32, width of the edge counter and captured counts.
- WINDOW_CYCLES, 1024, clk cycles puf_enable is held high per measurement (>= 1).
- SETTLE_CYCLES, 4, clk cycles waited after disable before capture (>= 1), for counter/synchroniser settling.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request; accepted only in IDLE.
- challenge_a  in  SEL_W  first oscillator index.
- challenge_b  in  SEL_W  second oscillator index.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when results are valid.
- response  out  1  1 when count_a > count_b.
- tie  out  1  1 when count_a == count_b.
- err  out  1  1 when the challenge is invalid.
- count_a  out  CNT_W  captured count of oscillator a.
- count_b  out  CNT_W  captured count of oscillator b.
- mux_enable  out  SEL_W  oscillator select to the chain.
- puf_enable  out  1  oscillator enable to the chain.
- reset_counter  out  1  counter clear to the chain.
- count_in  in  CNT_W  counter output from the chain.

Behaviour:
- Reset values:
  - all outputs 0;
  - state IDLE;
  - internal timer 0.
- Challenge latching: challenge_a and challenge_b are registered when start is accepted; later input changes are ignored.
- Challenge validation:
  - a challenge is invalid if a == b, or if either index >= NUM_RO;
  - invalid challenge: go to DONE next cycle, err=1, response=0, tie=0, counts=0, puf_enable never asserted.
- FSM states:
  - IDLE: wait for start.
  - CLR_A: 1 cycle. mux_enable=a, reset_counter=1, puf_enable=0.
  - RUN_A: WINDOW_CYCLES cycles. mux_enable=a, puf_enable=1.
  - SETTLE_A: SETTLE_CYCLES cycles. puf_enable=0, mux_enable held at a.
  - CAP_A: 1 cycle. count_a <= count_in.
  - CLR_B, RUN_B, SETTLE_B, CAP_B: same as the A states, using b and count_b.
  - DONE: 1 cycle. done=1, response and tie set from the registered counts. Then return to IDLE.
- Latency:
  - valid challenge: done asserts exactly 2*(WINDOW_CYCLES+SETTLE_CYCLES+2)+1 cycles after the start-sampling edge;
  - invalid challenge: done asserts exactly 1 cycle after the start-sampling edge.
- Result holding: response, tie, err, count_a and count_b hold until the next accepted start, then clear to 0 at acceptance.
- Enable rule: puf_enable is high only in RUN_A and RUN_B. It never overlaps reset_counter.
- Select rule: mux_enable changes only in CLR states, while puf_enable is low.
- Comparison: unsigned compare of CNT_W values. A tie gives response=0, tie=1.
- Counter wrap: the counter wrapping within the window is not detected; the count is taken modulo 2^CNT_W.
- start while busy (any non-IDLE state, including DONE): ignored, no queueing.
- start in the same cycle as reset: reset wins.
- reset mid-operation: next cycle all outputs are 0, including puf_enable, and the state is IDLE.

Decomposition:
- Package ro_puf_pkg:
  - state enum;
  - the localparam for the timer width, $clog2(max(WINDOW_CYCLES, SETTLE_CYCLES)+1);
  - the challenge-valid function.
- Sub-module ro_window_timer:
  - loadable down-counter with load and expire outputs;
  - reused for the RUN and SETTLE phases.

Test Plan:
- Bench setup for all scenarios:
  - NUM_RO=4, WINDOW_CYCLES=16, SETTLE_CYCLES=4;
  - behavioural counter model that increments count_in by a per-oscillator rate each cycle puf_enable is high;
  - rates 3, 5, 2, 7.
- Scenario 1: start, a=1, b=2 -> count_a=80, count_b=32, response=1, tie=0, err=0. done pulses exactly 45 cycles after start. busy is high for the 44 cycles before done.
- Scenario 2: start, a=2, b=3 -> count_a=32, count_b=112, response=0, tie=0. Check puf_enable is high for exactly 16 cycles per phase, with exactly one reset_counter pulse before each phase.
- Scenario 3: set oscillator 0 and oscillator 1 to equal rate 5, start, a=0, b=1 -> count_a=count_b=80, tie=1, response=0.
- Scenario 4: invalid challenges:
  - start, a=b=1 -> done 1 cycle later, err=1, puf_enable never high;
  - repeat with NUM_RO=3 and a=3 -> err=1.
- Scenario 5: start again at cycle 10 of a measurement -> ignored, challenge unchanged, single done pulse.
- Scenario 6: assert reset during RUN_B -> next cycle puf_enable=0, busy=0, counts=0, state IDLE. A following start, a=1, b=2, completes normally with count_a=80, count_b=32.

Source files
------------

// File: rtl/ro_puf_pkg.sv
// Shared types and helpers for the ring-oscillator PUF measurement sequencer.
package ro_puf_pkg;

  // Sequencer states: each oscillator gets clear / run / settle / capture.
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_CLR_A    = 4'd1,
    ST_RUN_A    = 4'd2,
    ST_SETTLE_A = 4'd3,
    ST_CAP_A    = 4'd4,
    ST_CLR_B    = 4'd5,
    ST_RUN_B    = 4'd6,
    ST_SETTLE_B = 4'd7,
    ST_CAP_B    = 4'd8,
    ST_DONE     = 4'd9
  } state_e;

  localparam int unsigned DEF_WINDOW_CYCLES = 32'd1024;
  localparam int unsigned DEF_SETTLE_CYCLES = 32'd4;

  // Timer must hold the larger of the two phase lengths.
  function automatic int unsigned timer_width(input int unsigned window_cycles,
                                              input int unsigned settle_cycles);
    int unsigned longest;
    longest = (window_cycles > settle_cycles) ? window_cycles : settle_cycles;
    return $clog2(longest + 32'd1);
  endfunction

  localparam int unsigned TMR_W = timer_width(DEF_WINDOW_CYCLES, DEF_SETTLE_CYCLES);

  // A challenge must name two distinct, existing oscillators.
  function automatic logic challenge_valid(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned num_ro);
    return (a != b) && (a < num_ro) && (b < num_ro);
  endfunction

endpackage

// File: rtl/ro_window_timer.sv
// Loadable down-counter timing the RUN and SETTLE phases.
// expire_o is high during the last cycle of a loaded interval, so a load of N
// followed by waiting for expire_o spans exactly N cycles.
module ro_window_timer
  import ro_puf_pkg::*;
#(
  parameter int unsigned TW = TMR_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic [TW-1:0] load_val_i,
  output logic          expire_o
);

  localparam logic [TW-1:0] ONE = TW'(1);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  // Next count: load wins, otherwise count down and park at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = (count_q == ONE);

endmodule

// File: rtl/ro_puf_controller.sv
// Measurement sequencer for the ring-oscillator PUF chain: measures two
// selected oscillators over a fixed gate window and compares their counts.
// All outputs are registered and change together with the state register.
module ro_puf_controller
  import ro_puf_pkg::*;
#(
  parameter int unsigned NUM_RO        = 4,
  parameter int unsigned SEL_W         = $clog2(NUM_RO),
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned WINDOW_CYCLES = 1024,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [SEL_W-1:0] challenge_a,
  input  logic [SEL_W-1:0] challenge_b,
  output logic             busy,
  output logic             done,
  output logic             response,
  output logic             tie,
  output logic             err,
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_b,
  output logic [SEL_W-1:0] mux_enable,
  output logic             puf_enable,
  output logic             reset_counter,
  input  logic [CNT_W-1:0] count_in
);

  localparam int unsigned TW = timer_width(WINDOW_CYCLES, SETTLE_CYCLES);
  localparam logic [TW-1:0] WIN_LOAD = TW'(WINDOW_CYCLES);
  localparam logic [TW-1:0] SET_LOAD = TW'(SETTLE_CYCLES);

  state_e           state_q;
  logic [SEL_W-1:0] chal_b_q;
  logic             busy_q;
  logic             done_q;
  logic             response_q;
  logic             tie_q;
  logic             err_q;
  logic [CNT_W-1:0] count_a_q;
  logic [CNT_W-1:0] count_b_q;
  logic [SEL_W-1:0] mux_q;
  logic             puf_en_q;
  logic             rst_cnt_q;

  logic             load_s;
  logic [TW-1:0]    load_val_s;
  logic             expire_s;
  logic             chal_ok_s;

  assign chal_ok_s = challenge_valid(32'(challenge_a), 32'(challenge_b), NUM_RO);

  // Timer loads the window length leaving CLR and the settle length leaving RUN.
  always_comb begin
    load_s     = 1'b0;
    load_val_s = WIN_LOAD;
    case (state_q)
      ST_CLR_A, ST_CLR_B: begin
        load_s     = 1'b1;
        load_val_s = WIN_LOAD;
      end
      ST_RUN_A, ST_RUN_B: begin
        load_s     = expire_s;
        load_val_s = SET_LOAD;
      end
      default: begin
        load_s     = 1'b0;
        load_val_s = WIN_LOAD;
      end
    endcase
  end

  ro_window_timer #(
    .TW(TW)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load_i    (load_s),
    .load_val_i(load_val_s),
    .expire_o  (expire_s)
  );

  // Sequencer FSM; every output register is updated on the same edge as the
  // state it belongs to, so outputs always match state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      chal_b_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      response_q <= 1'b0;
      tie_q      <= 1'b0;
      err_q      <= 1'b0;
      count_a_q  <= '0;
      count_b_q  <= '0;
      mux_q      <= '0;
      puf_en_q   <= 1'b0;
      rst_cnt_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            chal_b_q   <= challenge_b;
            response_q <= 1'b0;
            tie_q      <= 1'b0;
            count_a_q  <= '0;
            count_b_q  <= '0;
            if (chal_ok_s) begin
              state_q   <= ST_CLR_A;
              busy_q    <= 1'b1;
              err_q     <= 1'b0;
              mux_q     <= challenge_a;
              rst_cnt_q <= 1'b1;
            end else begin
              // Invalid challenge never touches the oscillator chain.
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              err_q   <= 1'b1;
              done_q  <= 1'b1;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_CLR_A: begin
          state_q   <= ST_RUN_A;
          rst_cnt_q <= 1'b0;
          puf_en_q  <= 1'b1;
        end
        ST_RUN_A: begin
          if (expire_s) begin
            state_q  <= ST_SETTLE_A;
            puf_en_q <= 1'b0;
          end else begin
            state_q <= ST_RUN_A;
          end
        end
        ST_SETTLE_A: begin
          if (expire_s) begin
            state_q <= ST_CAP_A;
          end else begin
            state_q <= ST_SETTLE_A;
          end
        end
        ST_CAP_A: begin
          count_a_q <= count_in;
          state_q   <= ST_CLR_B;
          mux_q     <= chal_b_q;
          rst_cnt_q <= 1'b1;
        end
        ST_CLR_B: begin
          state_q   <= ST_RUN_B;
          rst_cnt_q <= 1'b0;
          puf_en_q  <= 1'b1;
        end
        ST_RUN_B: begin
          if (expire_s) begin
            state_q  <= ST_SETTLE_B;
            puf_en_q <= 1'b0;
          end else begin
            state_q <= ST_RUN_B;
          end
        end
        ST_SETTLE_B: begin
          if (expire_s) begin
            state_q <= ST_CAP_B;
          end else begin
            state_q <= ST_SETTLE_B;
          end
        end
        ST_CAP_B: begin
          // count_b is captured on this same edge, so compare against count_in.
          count_b_q  <= count_in;
          response_q <= (count_a_q > count_in);
          tie_q      <= (count_a_q == count_in);
          busy_q     <= 1'b0;
          done_q     <= 1'b1;
          state_q    <= ST_DONE;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q   <= ST_IDLE;
          busy_q    <= 1'b0;
          puf_en_q  <= 1'b0;
          rst_cnt_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign response      = response_q;
  assign tie           = tie_q;
  assign err           = err_q;
  assign count_a       = count_a_q;
  assign count_b       = count_b_q;
  assign mux_enable    = mux_q;
  assign puf_enable    = puf_en_q;
  assign reset_counter = rst_cnt_q;

endmodule

// File: tb/tb_ro_puf_controller.sv
// Directed self-checking bench for ro_puf_controller with a behavioural
// oscillator/counter chain model (per-oscillator rate per enabled cycle).
module tb_ro_puf_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  challenge_a = 2'd0;
  logic [1:0]  challenge_b = 2'd0;
  logic        busy, done, response, tie, err;
  logic [31:0] count_a, count_b;
  logic [1:0]  mux_enable;
  logic        puf_enable, reset_counter;
  logic [31:0] cnt_q = 32'd0;

  logic        busy3, done3, response3, tie3, err3;
  logic [31:0] count_a3, count_b3;
  logic [1:0]  mux_enable3;
  logic        puf_enable3, reset_counter3;
  logic [31:0] count_in3;

  int rate [4];
  int checks = 0;
  int errors = 0;

  assign count_in3 = 32'd0;

  always #5 clk = ~clk;

  // Counter chain model.
  always @(posedge clk) begin
    if (reset_counter) cnt_q <= 32'd0;
    else if (puf_enable) cnt_q <= cnt_q + 32'(rate[mux_enable]);
  end

  ro_puf_controller #(.NUM_RO(4), .CNT_W(32), .WINDOW_CYCLES(16), .SETTLE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .start(start), .challenge_a(challenge_a), .challenge_b(challenge_b),
    .busy(busy), .done(done), .response(response), .tie(tie), .err(err),
    .count_a(count_a), .count_b(count_b), .mux_enable(mux_enable), .puf_enable(puf_enable),
    .reset_counter(reset_counter), .count_in(cnt_q));

  ro_puf_controller #(.NUM_RO(3), .CNT_W(32), .WINDOW_CYCLES(16), .SETTLE_CYCLES(4)) dut3 (
    .clk(clk), .reset(reset), .start(start), .challenge_a(challenge_a), .challenge_b(challenge_b),
    .busy(busy3), .done(done3), .response(response3), .tie(tie3), .err(err3),
    .count_a(count_a3), .count_b(count_b3), .mux_enable(mux_enable3), .puf_enable(puf_enable3),
    .reset_counter(reset_counter3), .count_in(count_in3));

  // Called at a falling edge; start is sampled by the next rising edge (k=0),
  // and the task returns at the following falling edge (observation k=1).
  task automatic do_start(input logic [1:0] a, input logic [1:0] b);
    challenge_a = a; challenge_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; challenge_a = ~a; challenge_b = ~b;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, response, tie, err, puf_enable, reset_counter} !== 7'd0 ||
        count_a !== 32'd0 || count_b !== 32'd0 || mux_enable !== 2'd0) begin
      errors++; $display("FAIL reset_outputs: got ctl=%b ca=%0d cb=%0d mux=%0d expected all 0",
        {busy, done, response, tie, err, puf_enable, reset_counter}, count_a, count_b, mux_enable);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || puf_enable !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: busy=%b done=%b puf=%b expected 0", busy, done, puf_enable);
    end
  endtask

  task automatic test_basic;
    int done_k = 0; int busy_cnt = 0;
    do_start(2'd1, 2'd2);
    for (int k = 1; k <= 100; k++) begin
      if (done) begin done_k = k; break; end
      if (busy) busy_cnt++;
      @(negedge clk);
    end
    checks++;
    if (done_k !== 45) begin errors++; $display("FAIL s1_done_latency: got %0d expected 45", done_k); end
    checks++;
    if (busy_cnt !== 44) begin errors++; $display("FAIL s1_busy_cycles: got %0d expected 44", busy_cnt); end
    checks++;
    if (count_a !== 32'd80 || count_b !== 32'd32) begin
      errors++; $display("FAIL s1_counts: got %0d/%0d expected 80/32", count_a, count_b);
    end
    checks++;
    if (response !== 1'b1 || tie !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL s1_flags: got resp=%b tie=%b err=%b busy=%b expected 1 0 0 0", response, tie, err, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || count_a !== 32'd80 || response !== 1'b1) begin
      errors++; $display("FAIL s1_hold: got done=%b ca=%0d resp=%b expected 0 80 1", done, count_a, response);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_enable_window;
    int en_a = 0; int en_b = 0; int rc_a = 0; int rc_b = 0; int bad = 0; int done_k = 0;
    logic [1:0] prev_mux;
    prev_mux = mux_enable;
    do_start(2'd2, 2'd3);
    for (int k = 1; k <= 100; k++) begin
      if (puf_enable && mux_enable == 2'd2) en_a++;
      if (puf_enable && mux_enable == 2'd3) en_b++;
      if (reset_counter && mux_enable == 2'd2) rc_a++;
      if (reset_counter && mux_enable == 2'd3) rc_b++;
      if (puf_enable && reset_counter) bad++;
      if (mux_enable != prev_mux && (puf_enable || !reset_counter)) bad++;
      prev_mux = mux_enable;
      if (done) begin done_k = k; break; end
      @(negedge clk);
    end
    checks++;
    if (en_a !== 16 || en_b !== 16) begin
      errors++; $display("FAIL s2_enable_cycles: got %0d/%0d expected 16/16", en_a, en_b);
    end
    checks++;
    if (rc_a !== 1 || rc_b !== 1 || bad !== 0) begin
      errors++; $display("FAIL s2_clear_rules: got rc=%0d/%0d violations=%0d expected 1/1/0", rc_a, rc_b, bad);
    end
    checks++;
    if (done_k !== 45 || count_a !== 32'd32 || count_b !== 32'd112 || response !== 1'b0 || tie !== 1'b0) begin
      errors++; $display("FAIL s2_result: got k=%0d ca=%0d cb=%0d resp=%b tie=%b expected 45 32 112 0 0",
        done_k, count_a, count_b, response, tie);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_tie;
    int done_k = 0;
    rate[0] = 5;
    do_start(2'd0, 2'd1);
    for (int k = 1; k <= 100; k++) begin
      if (done) begin done_k = k; break; end
      @(negedge clk);
    end
    checks++;
    if (done_k !== 45 || count_a !== 32'd80 || count_b !== 32'd80 || tie !== 1'b1 || response !== 1'b0) begin
      errors++; $display("FAIL s3_tie: got k=%0d ca=%0d cb=%0d tie=%b resp=%b expected 45 80 80 1 0",
        done_k, count_a, count_b, tie, response);
    end
    rate[0] = 3;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_invalid;
    int puf_cnt = 0; int done_k = 0;
    do_start(2'd1, 2'd1);
    checks++;
    if (done !== 1'b1 || err !== 1'b1 || response !== 1'b0 || tie !== 1'b0 ||
        count_a !== 32'd0 || count_b !== 32'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL s4_same_index: got done=%b err=%b resp=%b tie=%b ca=%0d cb=%0d busy=%b expected 1 1 0 0 0 0 0",
        done, err, response, tie, count_a, count_b, busy);
    end
    for (int k = 1; k <= 6; k++) begin
      if (puf_enable || reset_counter) puf_cnt++;
      @(negedge clk);
    end
    checks++;
    if (puf_cnt !== 0 || done !== 1'b0 || err !== 1'b1) begin
      errors++; $display("FAIL s4_chain_idle: got chain_cycles=%0d done=%b err=%b expected 0 0 1", puf_cnt, done, err);
    end
    do_start(2'd3, 2'd0);
    checks++;
    if (done3 !== 1'b1 || err3 !== 1'b1 || puf_enable3 !== 1'b0) begin
      errors++; $display("FAIL s4_out_of_range: got done=%b err=%b puf=%b expected 1 1 0", done3, err3, puf_enable3);
    end
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL s4_valid_on_4: got err=%b busy=%b expected 0 1", err, busy);
    end
    for (int k = 1; k <= 100; k++) begin
      if (done) begin done_k = k; break; end
      @(negedge clk);
    end
    checks++;
    if (done_k !== 45 || count_a !== 32'd112 || count_b !== 32'd48) begin
      errors++; $display("FAIL s4_idx3_run: got k=%0d ca=%0d cb=%0d expected 45 112 48", done_k, count_a, count_b);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_start_while_busy;
    int dones = 0; int first_k = 0;
    do_start(2'd1, 2'd2);
    for (int k = 1; k <= 70; k++) begin
      if (k == 10) begin start = 1'b1; challenge_a = 2'd3; challenge_b = 2'd0; end
      if (k == 11) start = 1'b0;
      if (done) begin dones++; if (first_k == 0) first_k = k; end
      @(negedge clk);
    end
    checks++;
    if (dones !== 1 || first_k !== 45) begin
      errors++; $display("FAIL s5_single_done: got pulses=%0d first=%0d expected 1 45", dones, first_k);
    end
    checks++;
    if (count_a !== 32'd80 || count_b !== 32'd32 || response !== 1'b1) begin
      errors++; $display("FAIL s5_challenge_kept: got ca=%0d cb=%0d resp=%b expected 80 32 1", count_a, count_b, response);
    end
  endtask

  task automatic test_reset_mid_run;
    int done_k = 0;
    do_start(2'd1, 2'd2);
    repeat (29) @(negedge clk);
    checks++;
    if (puf_enable !== 1'b1 || mux_enable !== 2'd2 || count_a !== 32'd80) begin
      errors++; $display("FAIL s6_in_run_b: got puf=%b mux=%0d ca=%0d expected 1 2 80", puf_enable, mux_enable, count_a);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (puf_enable !== 1'b0 || busy !== 1'b0 || count_a !== 32'd0 || count_b !== 32'd0 ||
        mux_enable !== 2'd0 || reset_counter !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL s6_reset_clears: got puf=%b busy=%b ca=%0d cb=%0d mux=%0d rc=%b done=%b expected all 0",
        puf_enable, busy, count_a, count_b, mux_enable, reset_counter, done);
    end
    reset = 1'b0;
    @(negedge clk);
    do_start(2'd1, 2'd2);
    for (int k = 1; k <= 100; k++) begin
      if (done) begin done_k = k; break; end
      @(negedge clk);
    end
    checks++;
    if (done_k !== 45 || count_a !== 32'd80 || count_b !== 32'd32 || response !== 1'b1) begin
      errors++; $display("FAIL s6_restart: got k=%0d ca=%0d cb=%0d resp=%b expected 45 80 32 1",
        done_k, count_a, count_b, response);
    end
  endtask

  initial begin
    rate[0] = 3; rate[1] = 5; rate[2] = 2; rate[3] = 7;
    test_reset();
    test_basic();
    test_enable_window();
    test_tie();
    test_invalid();
    test_start_while_busy();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
